// File: rtl/exp_cordic_sequencer.sv
// Transaction front-end for the CORDIC exponential core: one core run per accepted argument.
// Optional watchdog in WAIT is enabled by defining EXP_SEQ_TIMEOUT_EN.
module exp_cordic_sequencer #(
  parameter int P       = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [P-1:0] in_t,
  output logic [P-1:0] core_t,
  output logic         core_rst_ex,
  output logic         core_begin,
  input  logic         core_ack_ex,
  input  logic [P-1:0] core_result,
  input  logic [3:0]   core_of,
  input  logic [3:0]   core_uf,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [P-1:0] out_result,
  output logic [7:0]   out_flags,
  output logic         out_timeout,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RSTC,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state;

`ifdef EXP_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Abort fires on the WAIT cycle whose increment would bring the counter to TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_r;

  assign out_timeout = timeout_r;
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = 32'(TIMEOUT);
  assign out_timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      in_ready    <= 1'b0;
      core_t      <= '0;
      core_rst_ex <= 1'b1;
      core_begin  <= 1'b0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_flags   <= '0;
      busy        <= 1'b0;
`ifdef EXP_SEQ_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_r   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          in_ready    <= 1'b1;
          core_rst_ex <= 1'b0;
          if (in_valid && in_ready) begin
            core_t      <= in_t;
            in_ready    <= 1'b0;
            core_rst_ex <= 1'b1;
            busy        <= 1'b1;
            state       <= S_RSTC;
          end
        end

        S_RSTC: begin
          core_rst_ex <= 1'b0;
          core_begin  <= 1'b1;
          state       <= S_START;
        end

        S_START: begin
          core_begin <= 1'b0;
`ifdef EXP_SEQ_TIMEOUT_EN
          wait_cnt   <= '0;
`endif
          state      <= S_WAIT;
        end

        S_WAIT: begin
          // A late ACK on the watchdog cycle still wins over the abort.
          if (core_ack_ex) begin
            out_result <= core_result;
            out_flags  <= {core_uf, core_of};
            out_valid  <= 1'b1;
`ifdef EXP_SEQ_TIMEOUT_EN
            timeout_r  <= 1'b0;
`endif
            state      <= S_DONE;
          end
`ifdef EXP_SEQ_TIMEOUT_EN
          else if (wait_cnt == CNT_LAST) begin
            out_result <= '0;
            out_flags  <= '0;
            out_valid  <= 1'b1;
            timeout_r  <= 1'b1;
            state      <= S_DONE;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exp_cordic_sequencer.sv
// Directed self-checking bench for exp_cordic_sequencer; the watchdog scenario follows EXP_SEQ_TIMEOUT_EN.
module tb_exp_cordic_sequencer;

  localparam int P       = 32;
  localparam int TIMEOUT = 16;
`ifdef EXP_SEQ_TIMEOUT_EN
  localparam int ACK_CYC = 12;
`else
  localparam int ACK_CYC = 40;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [P-1:0] in_t;
  logic [P-1:0] core_t;
  logic         core_rst_ex;
  logic         core_begin;
  logic         core_ack_ex;
  logic [P-1:0] core_result;
  logic [3:0]   core_of;
  logic [3:0]   core_uf;
  logic         out_valid;
  logic         out_ready;
  logic [P-1:0] out_result;
  logic [7:0]   out_flags;
  logic         out_timeout;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  exp_cordic_sequencer #(.P(P), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_t        (in_t),
    .core_t      (core_t),
    .core_rst_ex (core_rst_ex),
    .core_begin  (core_begin),
    .core_ack_ex (core_ack_ex),
    .core_result (core_result),
    .core_of     (core_of),
    .core_uf     (core_uf),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_flags   (out_flags),
    .out_timeout (out_timeout),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, core_rst_ex, core_begin, out_valid, out_timeout, busy} !== 6'b010000) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 010000",
               {in_ready, core_rst_ex, core_begin, out_valid, out_timeout, busy});
    end
    n_tests++;
    if ({core_t, out_result, out_flags} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got %h/%h/%h want 0", core_t, out_result, out_flags);
    end
    step();
    rst_n = 1'b1;
    step();
    n_tests++;
    if ({in_ready, core_rst_ex, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_release got %b want 100", {in_ready, core_rst_ex, busy});
    end
  endtask

  task automatic test_single_op();
    bit bad;
    in_t = 32'h3F00_0000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_tests++;
    if ({core_rst_ex, core_begin, in_ready, busy} !== 4'b1001 || core_t !== 32'h3F00_0000) begin
      n_fail++;
      $display("FAIL single_rstc got %b t=%h want 1001 t=3f000000",
               {core_rst_ex, core_begin, in_ready, busy}, core_t);
    end
    step();
    n_tests++;
    if ({core_rst_ex, core_begin} !== 2'b01) begin
      n_fail++;
      $display("FAIL single_begin got %b want 01", {core_rst_ex, core_begin});
    end
    step();
    bad = 1'b0;
    for (int c = 3; c < ACK_CYC; c++) begin
      if (out_valid !== 1'b0 || core_begin !== 1'b0) bad = 1'b1;
      step();
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL single_wait got early out_valid/core_begin want 0");
    end
    core_ack_ex = 1'b1;
    core_result = 32'h3FD3_094C;
    core_of = 4'h0;
    core_uf = 4'h0;
    step();
    core_ack_ex = 1'b0;
    core_result = '0;
    n_tests++;
    if ({out_valid, out_timeout, in_ready} !== 3'b100 || out_result !== 32'h3FD3_094C ||
        out_flags !== 8'h00) begin
      n_fail++;
      $display("FAIL single_result got v/to/rdy=%b res=%h flg=%h want 100 3fd3094c 00",
               {out_valid, out_timeout, in_ready}, out_result, out_flags);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_tests++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL single_handshake got %b want 010", {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_back_to_back();
    in_t = 32'h4049_0FDB;
    in_valid = 1'b1;
    step();
    in_t = 32'hC000_0000;
    step();
    step();
    core_ack_ex = 1'b1;
    core_result = 32'h41AD_6E6C;
    core_of = 4'b0001;
    core_uf = 4'b1000;
    step();
    core_ack_ex = 1'b0;
    core_result = '0;
    core_of = 4'h0;
    core_uf = 4'h0;
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if ({out_valid, in_ready} !== 2'b10 || out_result !== 32'h41AD_6E6C ||
          out_flags !== 8'b1000_0001 || core_t !== 32'h4049_0FDB) begin
        n_fail++;
        $display("FAIL backpressure[%0d] got v/rdy=%b res=%h flg=%b t=%h want 10 41ad6e6c 10000001 40490fdb",
                 i, {out_valid, in_ready}, out_result, out_flags, core_t);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_tests++;
    if ({out_valid, in_ready} !== 2'b01 || core_t !== 32'h4049_0FDB) begin
      n_fail++;
      $display("FAIL b2b_idle got v/rdy=%b t=%h want 01 40490fdb", {out_valid, in_ready}, core_t);
    end
    step();
    in_valid = 1'b0;
    n_tests++;
    if ({core_rst_ex, in_ready} !== 2'b10 || core_t !== 32'hC000_0000) begin
      n_fail++;
      $display("FAIL b2b_second_accept got rst/rdy=%b t=%h want 10 c0000000",
               {core_rst_ex, in_ready}, core_t);
    end
    step();
    step();
    // ACK held across WAIT, DONE and back into IDLE
    core_ack_ex = 1'b1;
    core_result = 32'h1234_5678;
    core_of = 4'b1111;
    step();
    core_result = 32'h8765_4321;
    core_of = 4'b0000;
    step();
    n_tests++;
    if (out_valid !== 1'b1 || out_result !== 32'h1234_5678 || out_flags !== 8'h0F) begin
      n_fail++;
      $display("FAIL ack_hold_capture got v=%b res=%h flg=%h want 1 12345678 0f",
               out_valid, out_result, out_flags);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    step();
    core_ack_ex = 1'b0;
    n_tests++;
    if ({out_valid, in_ready, busy, core_rst_ex} !== 4'b0100 || out_result !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL ack_hold_idle got %b res=%h want 0100 12345678",
               {out_valid, in_ready, busy, core_rst_ex}, out_result);
    end
  endtask

  task automatic test_timeout();
    bit bad;
    in_t = 32'h3F80_0000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    n_tests++;
    if (core_begin !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_begin got %b want 1", core_begin);
    end
`ifdef EXP_SEQ_TIMEOUT_EN
    bad = 1'b0;
    for (int j = 1; j <= 15; j++) begin
      step();
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    step();
    n_tests++;
    if (bad || {out_valid, out_timeout} !== 2'b11 || out_result !== '0 || out_flags !== 8'h00) begin
      n_fail++;
      $display("FAIL timeout_abort got early=%0d v/to=%b res=%h flg=%h want 0 11 0 0",
               bad, {out_valid, out_timeout}, out_result, out_flags);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    for (int j = 1; j <= 15; j++) step();
    core_ack_ex = 1'b1;
    core_result = 32'h4000_0001;
    step();
    core_ack_ex = 1'b0;
    n_tests++;
    if ({out_valid, out_timeout} !== 2'b10 || out_result !== 32'h4000_0001) begin
      n_fail++;
      $display("FAIL timeout_ack_wins got v/to=%b res=%h want 10 40000001",
               {out_valid, out_timeout}, out_result);
    end
`else
    bad = 1'b0;
    for (int j = 1; j <= 30; j++) begin
      step();
      if (out_valid !== 1'b0 || out_timeout !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL no_watchdog got early out_valid/out_timeout want 0");
    end
    core_ack_ex = 1'b1;
    core_result = 32'h4000_0001;
    step();
    core_ack_ex = 1'b0;
    n_tests++;
    if ({out_valid, out_timeout} !== 2'b10 || out_result !== 32'h4000_0001) begin
      n_fail++;
      $display("FAIL no_watchdog_ack got v/to=%b res=%h want 10 40000001",
               {out_valid, out_timeout}, out_result);
    end
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_abort();
    in_t = 32'hBF00_0000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, core_rst_ex, busy, in_ready} !== 4'b0100 || core_t !== '0 || out_result !== '0) begin
      n_fail++;
      $display("FAIL abort_reset got %b t=%h res=%h want 0100 0 0",
               {out_valid, core_rst_ex, busy, in_ready}, core_t, out_result);
    end
    step();
    rst_n = 1'b1;
    step();
    core_ack_ex = 1'b1;
    core_result = 32'hDEAD_BEEF;
    step();
    step();
    core_ack_ex = 1'b0;
    n_tests++;
    if ({out_valid, in_ready, busy, core_rst_ex} !== 4'b0100 || out_result !== '0) begin
      n_fail++;
      $display("FAIL abort_late_ack got %b res=%h want 0100 0",
               {out_valid, in_ready, busy, core_rst_ex}, out_result);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit exceeded");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n       = 1'b1;
    in_valid    = 1'b0;
    in_t        = '0;
    core_ack_ex = 1'b0;
    core_result = '0;
    core_of     = '0;
    core_uf     = '0;
    out_ready   = 1'b0;
    test_reset();
    test_single_op();
    test_back_to_back();
    test_timeout();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
